// File: rtl/svc_axi_pkg.sv
// Shared AXI encodings and the memory-checker FSM state type.
package svc_axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      CHK_IDLE    = 3'd0,
      CHK_WR_ADDR = 3'd1,
      CHK_WR_DATA = 3'd2,
      CHK_WR_RESP = 3'd3,
      CHK_RD_ADDR = 3'd4,
      CHK_RD_DATA = 3'd5,
      CHK_DONE    = 3'd6
   } chk_state_e;

endpackage

// File: rtl/svc_axi_mem_checker_pattern.sv
// Beat index / address generator shared by the write and read phases.
// Expected word for beat i is seed ^ i; beat address is base + i*STRB (wrapping).
module svc_axi_mem_checker_pattern #(
   parameter int AXI_ADDR_WIDTH = 8,
   parameter int AXI_DATA_WIDTH = 16,
   parameter int NB_WIDTH       = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load,
   input  logic                      rewind,
   input  logic                      advance,
   input  logic [AXI_ADDR_WIDTH-1:0] base_addr,
   input  logic [AXI_DATA_WIDTH-1:0] seed,
   output logic [AXI_ADDR_WIDTH-1:0] beat_addr,
   output logic [AXI_DATA_WIDTH-1:0] exp_data
);
   import svc_axi_pkg::*;

   localparam int STRB  = AXI_DATA_WIDTH / 8;
   localparam int IDX_W = NB_WIDTH + 8;

   logic [IDX_W-1:0]          idx_q;
   logic [AXI_ADDR_WIDTH-1:0] base_q;
   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic [AXI_DATA_WIDTH-1:0] seed_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= '0;
         base_q <= '0;
         addr_q <= '0;
         seed_q <= '0;
      end else if (load) begin
         base_q <= base_addr;
         seed_q <= seed;
         addr_q <= base_addr;
         idx_q  <= '0;
      end else if (rewind) begin
         addr_q <= base_q;
         idx_q  <= '0;
      end else if (advance) begin
         addr_q <= addr_q + AXI_ADDR_WIDTH'(STRB);
         idx_q  <= idx_q + IDX_W'(1);
      end
   end

   assign beat_addr = addr_q;
   assign exp_data  = seed_q ^ AXI_DATA_WIDTH'(idx_q);

endmodule

// File: rtl/svc_axi_mem_checker.sv
// AXI4 manager that writes seed^i over a region with INCR bursts, reads it back and
// reports pass plus the first failing address/data. Optional wvalid/rready throttling
// is compiled in with SVC_AXI_MEM_CHECKER_THROTTLE_EN.
module svc_axi_mem_checker #(
   parameter int AXI_ADDR_WIDTH = 8,
   parameter int AXI_DATA_WIDTH = 16,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int BURST_LEN      = 4,
   parameter int NB_WIDTH       = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [AXI_ADDR_WIDTH-1:0]   base_addr,
   input  logic [NB_WIDTH-1:0]         num_bursts,
   input  logic [AXI_DATA_WIDTH-1:0]   seed,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic [AXI_ADDR_WIDTH-1:0]   err_addr,
   output logic [AXI_DATA_WIDTH-1:0]   err_data,
   output logic [2:0]                  state_dbg,
   output logic                        m_axi_awvalid,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
   output logic [7:0]                  m_axi_awlen,
   output logic [2:0]                  m_axi_awsize,
   output logic [1:0]                  m_axi_awburst,
   input  logic                        m_axi_awready,
   output logic                        m_axi_wvalid,
   output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                        m_axi_wlast,
   input  logic                        m_axi_wready,
   input  logic                        m_axi_bvalid,
   input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
   input  logic [1:0]                  m_axi_bresp,
   output logic                        m_axi_bready,
   output logic                        m_axi_arvalid,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
   output logic [7:0]                  m_axi_arlen,
   output logic [2:0]                  m_axi_arsize,
   output logic [1:0]                  m_axi_arburst,
   input  logic                        m_axi_arready,
   input  logic                        m_axi_rvalid,
   input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
   input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                  m_axi_rresp,
   input  logic                        m_axi_rlast,
   output logic                        m_axi_rready
);
   import svc_axi_pkg::*;

   localparam int         STRB      = AXI_DATA_WIDTH / 8;
   localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

   chk_state_e                state_q, state_d;
   logic [NB_WIDTH-1:0]       nb_q;
   logic [NB_WIDTH-1:0]       burst_q;
   logic [7:0]                beat_q;
   logic [AXI_ADDR_WIDTH-1:0] burst_addr_q;
   logic                      err_flag_q;
   logic [AXI_ADDR_WIDTH-1:0] err_addr_q;
   logic [AXI_DATA_WIDTH-1:0] err_data_q;
   logic                      pass_q;
   logic [AXI_ADDR_WIDTH-1:0] beat_addr;
   logic [AXI_DATA_WIDTH-1:0] exp_data;
   logic                      w_gate, r_gate;
   logic                      aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic                      last_beat, last_burst, b_bad, r_bad;

   // A transfer happens on the edge where valid and ready are both high. Our valids
   // never drop and our payload never changes until that edge; readies may drop freely.
   assign aw_hs = m_axi_awvalid && m_axi_awready;
   assign w_hs  = m_axi_wvalid  && m_axi_wready;
   assign b_hs  = m_axi_bvalid  && m_axi_bready;
   assign ar_hs = m_axi_arvalid && m_axi_arready;
   assign r_hs  = m_axi_rvalid  && m_axi_rready;

   assign last_beat  = (beat_q == LAST_BEAT);
   assign last_burst = (burst_q == nb_q - NB_WIDTH'(1));
   assign b_bad = (m_axi_bresp != AXI_RESP_OKAY) || (m_axi_bid != '0);
   assign r_bad = (m_axi_rdata != exp_data) || (m_axi_rresp != AXI_RESP_OKAY) ||
                  (m_axi_rid != '0) || (m_axi_rlast != last_beat);

`ifdef SVC_AXI_MEM_CHECKER_THROTTLE_EN
   logic tog_q, w_hold_q;
   // w_hold_q keeps wvalid up across an off-phase while a beat is still unaccepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         tog_q    <= 1'b0;
         w_hold_q <= 1'b0;
      end else begin
         tog_q    <= ~tog_q;
         w_hold_q <= m_axi_wvalid && !m_axi_wready;
      end
   end
   assign w_gate = tog_q || w_hold_q;
   assign r_gate = tog_q;
`else
   assign w_gate = 1'b1;
   assign r_gate = 1'b1;
`endif

   svc_axi_mem_checker_pattern #(
      .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
      .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
      .NB_WIDTH       (NB_WIDTH)
   ) u_pattern (
      .clk       (clk),
      .rst       (rst),
      .load      (state_q == CHK_IDLE && start),
      .rewind    (state_q == CHK_WR_RESP && b_hs && last_burst),
      .advance   (w_hs || r_hs),
      .base_addr (base_addr),
      .seed      (seed),
      .beat_addr (beat_addr),
      .exp_data  (exp_data)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= CHK_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CHK_IDLE:    if (start) state_d = (num_bursts == '0) ? CHK_DONE : CHK_WR_ADDR;
         CHK_WR_ADDR: if (aw_hs) state_d = CHK_WR_DATA;
         CHK_WR_DATA: if (w_hs && last_beat) state_d = CHK_WR_RESP;
         CHK_WR_RESP: if (b_hs) state_d = last_burst ? CHK_RD_ADDR : CHK_WR_ADDR;
         CHK_RD_ADDR: if (ar_hs) state_d = CHK_RD_DATA;
         CHK_RD_DATA: if (r_hs && last_beat) state_d = last_burst ? CHK_DONE : CHK_RD_ADDR;
         CHK_DONE:    state_d = CHK_IDLE;
         default:     state_d = CHK_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         nb_q         <= '0;
         burst_q      <= '0;
         beat_q       <= '0;
         burst_addr_q <= '0;
         err_flag_q   <= 1'b0;
         err_addr_q   <= '0;
         err_data_q   <= '0;
         pass_q       <= 1'b0;
      end else begin
         case (state_q)
            CHK_IDLE: if (start) begin
               nb_q       <= num_bursts;
               burst_q    <= '0;
               beat_q     <= '0;
               err_flag_q <= 1'b0;
               err_addr_q <= '0;
               err_data_q <= '0;
               pass_q     <= 1'b0;
            end
            CHK_WR_ADDR: if (aw_hs) burst_addr_q <= beat_addr;
            CHK_WR_DATA: if (w_hs) beat_q <= last_beat ? 8'd0 : beat_q + 8'd1;
            CHK_WR_RESP: if (b_hs) begin
               if (b_bad && !err_flag_q) begin
                  err_flag_q <= 1'b1;
                  err_addr_q <= burst_addr_q;
                  err_data_q <= '0;
               end
               burst_q <= last_burst ? '0 : burst_q + NB_WIDTH'(1);
            end
            CHK_RD_DATA: if (r_hs) begin
               if (r_bad && !err_flag_q) begin
                  err_flag_q <= 1'b1;
                  err_addr_q <= beat_addr;
                  err_data_q <= m_axi_rdata;
               end
               beat_q <= last_beat ? 8'd0 : beat_q + 8'd1;
               if (last_beat) burst_q <= burst_q + NB_WIDTH'(1);
            end
            CHK_DONE: pass_q <= !err_flag_q;
            default: ;
         endcase
      end
   end

   // pass is presented alongside the done pulse, then held from pass_q.
   assign busy      = (state_q != CHK_IDLE) && (state_q != CHK_DONE);
   assign done      = (state_q == CHK_DONE);
   assign pass      = (state_q == CHK_DONE) ? !err_flag_q : pass_q;
   assign err_addr  = err_addr_q;
   assign err_data  = err_data_q;
   assign state_dbg = state_q;

   assign m_axi_awvalid = (state_q == CHK_WR_ADDR);
   assign m_axi_awaddr  = beat_addr;
   assign m_axi_awid    = '0;
   assign m_axi_awlen   = LAST_BEAT;
   assign m_axi_awsize  = 3'($clog2(STRB));
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_wvalid  = (state_q == CHK_WR_DATA) && w_gate;
   assign m_axi_wdata   = exp_data;
   assign m_axi_wstrb   = '1;
   assign m_axi_wlast   = last_beat;
   assign m_axi_bready  = (state_q == CHK_WR_RESP);
   assign m_axi_arvalid = (state_q == CHK_RD_ADDR);
   assign m_axi_araddr  = beat_addr;
   assign m_axi_arid    = '0;
   assign m_axi_arlen   = LAST_BEAT;
   assign m_axi_arsize  = 3'($clog2(STRB));
   assign m_axi_arburst = AXI_BURST_INCR;
   assign m_axi_rready  = (state_q == CHK_RD_DATA) && r_gate;

endmodule

// File: doc/svc_axi_mem_checker.md
Name: svc_axi_mem_checker

Overview:
- AXI4 manager that exercises an AXI subordinate memory (e.g. the iCE40 AXI SRAM) from the initiator side.
- On start it writes a deterministic pattern using INCR bursts, reads the same region back with INCR bursts, and compares every beat.
- It reports done, pass, and the first failing address and data.
- Used in board bring-up and in benches as the counterpart of AXI subordinate memories.

Parameters:
- AXI_ADDR_WIDTH, 8: byte address width.
- AXI_DATA_WIDTH, 16: data bus width in bits; power of two, ≥8.
- AXI_ID_WIDTH, 4: ID width; all transactions use ID 0.
- BURST_LEN, 4: beats per burst, 1..256.
- NB_WIDTH, 8: width of the num_bursts input.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse that begins a test; ignored while busy
- base_addr  in  AXI_ADDR_WIDTH  start byte address; must be aligned to BURST_LEN*STRB bytes
- num_bursts  in  NB_WIDTH  number of bursts to write and then read
- seed  in  AXI_DATA_WIDTH  pattern seed
- busy  out  1  test in progress
- done  out  1  one-cycle pulse at completion
- pass  out  1  result of the last test, held until the next start
- err_addr  out  AXI_ADDR_WIDTH  address of the first failing beat
- err_data  out  AXI_DATA_WIDTH  rdata of the first failing beat
- m_axi_aw*  out/in  AW channel: awvalid, awaddr, awid, awlen[7:0], awsize[2:0], awburst[1:0] out; awready in
- m_axi_w*  out/in  W channel: wvalid, wdata, wstrb, wlast out; wready in
- m_axi_b*  in/out  B channel: bvalid, bid, bresp[1:0] in; bready out
- m_axi_ar*  out/in  AR channel: arvalid, araddr, arid, arlen, arsize, arburst out; arready in
- m_axi_r*  in/out  R channel: rvalid, rid, rdata, rresp[1:0], rlast in; rready out

Interface is decided: one clock; reset is synchronous and active-high.

Behaviour:
- Constants:
  - STRB = AXI_DATA_WIDTH/8.
  - awsize = arsize = $clog2(STRB).
  - awburst = arburst = 2'b01 (INCR).
  - awlen = arlen = BURST_LEN-1.
  - wstrb all ones; ids 0.
- Pattern: beat word index i counts 0.. across the whole test; expected data = seed ^ i, with i zero-extended/truncated to AXI_DATA_WIDTH.
- Beat address = base_addr + i*STRB, mod 2^AXI_ADDR_WIDTH (wrap is allowed, not an error).
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
  - IDLE: on start (with rst low), latch inputs, set busy=1, clear the error flag. If num_bursts==0, go to DONE; otherwise go to WR_ADDR.
  - WR_ADDR: awvalid=1, held stable until awready; then go to WR_DATA.
  - WR_DATA: wvalid=1 with the current pattern; advance on wready. wlast=1 on beat BURST_LEN-1. After the last beat handshakes, go to WR_RESP.
  - WR_RESP: bready=1. On bvalid, if bresp!=OKAY or bid!=0, record an error (err_data=0, err_addr=burst address). Then go to WR_ADDR for the next burst, or to RD_ADDR after the final burst, restarting the address and index counters at base.
  - RD_ADDR: arvalid=1 until arready; then go to RD_DATA.
  - RD_DATA: rready=1. On each rvalid&rready, compare the beat. Mismatch is any of: rdata!=expected, rresp!=OKAY, rid!=0, or rlast!=(beat==BURST_LEN-1). After the burst's last beat, go to RD_ADDR or DONE.
  - DONE: done=1 for one cycle; pass=!error; busy=0; return to IDLE.
- Error capture: only the first error is latched into err_addr/err_data; later errors are ignored. The test always runs to completion.
- Valid signals never drop before their handshake, and payload is stable while valid is high.
- Only one burst is outstanding at a time: AW precedes W, and no read is issued until all B responses are received.
- Reset values: busy=0, done=0, pass=0, err_addr=0, err_data=0, all valids=0, bready=0, rready=0.
- Reset mid-test: the FSM goes to IDLE at the next edge and all valids drop immediately. The subordinate is expected to be reset together with this block.
- A start pulse coincident with done is ignored; start is sampled only in IDLE.
- Counters: burst counter is NB_WIDTH bits; beat counter is 8 bits; index counter is NB_WIDTH+8 bits.

Optional Feature:
- Macro: SVC_AXI_MEM_CHECKER_THROTTLE_EN.
- Defined: wvalid and rready are deasserted on alternate cycles, driven by a free-running toggle. A valid is only withdrawn when no handshake is pending (wvalid drops only after the prior beat has handshaken). This exercises subordinate backpressure and bubble handling.
- Undefined: wvalid and rready stay high continuously within WR_DATA and RD_DATA.

Decomposition:
- Package svc_axi_pkg holds:
  - AXI_BURST_INCR = 2'b01
  - AXI_RESP_OKAY = 2'b00
  - AXI_RESP_SLVERR = 2'b10
  - a typedef enum for the checker FSM states.
- Natural sub-module: svc_axi_mem_checker_pattern. It holds the index counter and address generator and supplies expected data and beat address; it is shared by the write and read phases.

Test Plan:
- Against an SRAM model: base=0x00, num_bursts=4, BURST_LEN=4, seed=0xA5A5. 16 writes then 16 reads. done pulses once, pass=1, and the first read beat is 0xA5A5 with the last 0xA5AA.
- num_bursts=0, start → done one cycle later with pass=1 and no AXI valids asserted.
- Memory model corrupts the word at address 0x0A (forces 0x0000) → pass=0, err_addr=0x0A, err_data=0x0000. Test still completes 32 beats.
- Subordinate returns bresp=SLVERR on burst 2 → pass=0 and err_addr = burst base 0x08.
- Subordinate stalls awready/arready for 5 cycles and randomly drops wready/rready → awaddr/wdata stay stable while valid, and pass=1.
- Assert rst during WR_DATA beat 2 → next cycle all valids=0 and busy=0. A new start then runs to pass=1.
